// File: rtl/alu_secuenciador_botones.sv
// Button-driven loader for the ALU: sync + debounce + rising-edge pulse per button, then an ordered A/B/opcode/execute FSM.
// Latency: a press is captured DEBOUNCE_CYCLES+2 edges after it is first sampled; no backpressure, out-of-order presses are dropped.
module alu_secuenciador_botones #(
  parameter int CANT_SWITCHES   = 4,
  parameter int CANT_BOTONES    = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ANCHO_CONTADOR  = 20
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic [CANT_SWITCHES-1:0] i_switch,
  input  logic [CANT_BOTONES-1:0]  i_botones,
  output logic [CANT_SWITCHES-1:0] o_dato_a,
  output logic [CANT_SWITCHES-1:0] o_dato_b,
  output logic [CANT_SWITCHES-1:0] o_opcode,
  output logic                     o_start,
  output logic [2:0]               o_estado
);

  localparam int BTN_A  = 0;
  localparam int BTN_B  = 1;
  localparam int BTN_OP = 2;
  localparam int BTN_EX = 3;

  localparam logic [ANCHO_CONTADOR-1:0] CNT_MAX = ANCHO_CONTADOR'(DEBOUNCE_CYCLES - 1);
  localparam logic [ANCHO_CONTADOR-1:0] CNT_UNO = ANCHO_CONTADOR'(1);

  typedef enum logic [2:0] {
    ESPERA_A  = 3'd0,
    ESPERA_B  = 3'd1,
    ESPERA_OP = 3'd2,
    LISTO     = 3'd3,
    MOSTRAR   = 3'd4
  } estado_t;

  logic [CANT_BOTONES-1:0]   sync_1;
  logic [CANT_BOTONES-1:0]   sync_2;
  logic [CANT_BOTONES-1:0]   estable;
  logic [CANT_BOTONES-1:0]   pulso;
  logic [ANCHO_CONTADOR-1:0] contador [CANT_BOTONES];

  estado_t                  estado;
  estado_t                  estado_sig;
  logic [CANT_SWITCHES-1:0] dato_a_q;
  logic [CANT_SWITCHES-1:0] dato_b_q;
  logic [CANT_SWITCHES-1:0] opcode_q;
  logic [CANT_SWITCHES-1:0] dato_a_sig;
  logic [CANT_SWITCHES-1:0] dato_b_sig;
  logic [CANT_SWITCHES-1:0] opcode_sig;
  logic                     start_q;
  logic                     start_sig;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= i_botones;
      sync_2 <= sync_1;
    end
  end

  // The counter only runs while the synced level disagrees with the accepted one;
  // any agreeing cycle restarts the stability window.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      estable <= '0;
      pulso   <= '0;
      for (int i = 0; i < CANT_BOTONES; i++) begin
        contador[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CANT_BOTONES; i++) begin
        pulso[i] <= 1'b0;
        if (sync_2[i] == estable[i]) begin
          contador[i] <= '0;
        end else if (contador[i] == CNT_MAX) begin
          estable[i]  <= sync_2[i];
          contador[i] <= '0;
          pulso[i]    <= sync_2[i];
        end else begin
          contador[i] <= contador[i] + CNT_UNO;
        end
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      estado   <= ESPERA_A;
      dato_a_q <= '0;
      dato_b_q <= '0;
      opcode_q <= '0;
      start_q  <= 1'b0;
    end else begin
      estado   <= estado_sig;
      dato_a_q <= dato_a_sig;
      dato_b_q <= dato_b_sig;
      opcode_q <= opcode_sig;
      start_q  <= start_sig;
    end
  end

  always_comb begin
    estado_sig = estado;
    dato_a_sig = dato_a_q;
    dato_b_sig = dato_b_q;
    opcode_sig = opcode_q;
    start_sig  = 1'b0;
    case (estado)
      ESPERA_A: begin
        if (pulso[BTN_A]) begin
          dato_a_sig = i_switch;
          estado_sig = ESPERA_B;
        end
      end
      ESPERA_B: begin
        if (pulso[BTN_B]) begin
          dato_b_sig = i_switch;
          estado_sig = ESPERA_OP;
        end
      end
      ESPERA_OP: begin
        if (pulso[BTN_OP]) begin
          opcode_sig = i_switch;
          estado_sig = LISTO;
        end
      end
      LISTO: begin
        if (pulso[BTN_EX]) begin
          start_sig  = 1'b1;
          estado_sig = MOSTRAR;
        end
      end
      MOSTRAR: begin
        // A new operand A takes priority over a simultaneous re-execute.
        if (pulso[BTN_A]) begin
          dato_a_sig = i_switch;
          estado_sig = ESPERA_B;
        end else if (pulso[BTN_EX]) begin
          start_sig = 1'b1;
        end
      end
      default: begin
        estado_sig = ESPERA_A;
      end
    endcase
  end

  assign o_dato_a = dato_a_q;
  assign o_dato_b = dato_b_q;
  assign o_opcode = opcode_q;
  assign o_start  = start_q;
  assign o_estado = estado;

endmodule

// File: doc/alu_secuenciador_botones.md
Name: alu_secuenciador_botones

Overview:
- Front-end controller that sequences ALU operand/opcode loading from the board switches and buttons.
- Debounces and edge-detects each button, then runs an ordered load FSM: A, then B, then opcode, then execute.
- Holds captured operands and opcode stable and issues a one-cycle start pulse to the ALU.
- Sits between the board I/O (switches, buttons) and the ALU instance in the top level.

Parameters:
- CANT_SWITCHES, 4, width of switch bus, operand registers and opcode register.
- CANT_BOTONES, 4, number of buttons; fixed function map below, must be 4.
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required to accept a button level change (min 2).
- ANCHO_CONTADOR, 20, debounce counter width; must satisfy 2^ANCHO_CONTADOR > DEBOUNCE_CYCLES.

Ports:
- i_clock  in  1  system clock; all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_switch  in  CANT_SWITCHES  data/opcode source, sampled on load events.
- i_botones  in  CANT_BOTONES  raw asynchronous buttons: [0]=load A, [1]=load B, [2]=load opcode, [3]=execute.
- o_dato_a  out  CANT_SWITCHES  captured operand A.
- o_dato_b  out  CANT_SWITCHES  captured operand B.
- o_opcode  out  CANT_SWITCHES  captured opcode.
- o_start  out  1  one-cycle execute pulse to the ALU.
- o_estado  out  3  current FSM state encoding (for LEDs/debug).

Behaviour:
- Reset (async, active-high): all outputs and registers go to 0; FSM goes to ESPERA_A (encoding 3'd0); synchronizers, debounce counters and stable levels are cleared. Reset asserted mid-sequence discards all captured data.
- Per-button conditioning:
  - 2-FF synchronizer, then debounce counter.
  - While the synced level differs from the stable level, the counter increments; any cycle it matches, the counter clears to 0.
  - When the counter equals DEBOUNCE_CYCLES-1 and the level still differs, the stable level takes the synced value and the counter clears.
  - A registered pulse p[i] goes high for exactly 1 cycle on each stable 0->1 transition; releases produce no pulse.
  - Latency: input held high from edge 0 gives p[i] high after edge DEBOUNCE_CYCLES+1.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- FSM states: ESPERA_A=0, ESPERA_B=1, ESPERA_OP=2, LISTO=3, MOSTRAR=4.
  - ESPERA_A: p[0] captures i_switch into o_dato_a, then goes to ESPERA_B.
  - ESPERA_B: p[1] captures into o_dato_b, then goes to ESPERA_OP.
  - ESPERA_OP: p[2] captures into o_opcode, then goes to LISTO.
  - LISTO: p[3] asserts o_start for the next cycle only, then goes to MOSTRAR.
  - MOSTRAR: p[0] captures a new A and goes to ESPERA_B. p[3] re-issues o_start and stays in MOSTRAR.
  - Capture uses i_switch as sampled on the same edge the state transitions.
- Out-of-order presses (any pulse not listed for the current state) are ignored; registers hold.
- Simultaneous pulses in the same cycle: only the pulse valid for the current state acts. In MOSTRAR, p[0] wins over p[3] (no o_start).
- o_start is registered, 1 cycle wide, never asserted on consecutive cycles.
- Operand/opcode outputs change only on their capture event and are stable otherwise.
- Unused state encodings 5-7 return to ESPERA_A on the next edge with no output change.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset then idle -> all outputs 0, o_estado=0, o_start never asserted.
- Switch=4'h5 + btn0, 4'h3 + btn1, 4'h8 + btn2, btn3 (each held 10 cycles) -> o_dato_a=5, o_dato_b=3, o_opcode=8; o_start exactly 1 cycle; o_estado ends at 4. Pulse timing checked at DEBOUNCE_CYCLES+2 edges after press.
- 3-cycle glitch on btn0 in ESPERA_A -> no pulse, o_estado stays 0, o_dato_a unchanged.
- In ESPERA_A press btn1, btn2, btn3 -> no state change, no capture, no o_start.
- In MOSTRAR press btn3 twice -> two separate 1-cycle o_start pulses. Then btn0 and btn3 together with switch=4'hA -> o_dato_a=A, o_estado=1, no o_start.
- Assert i_reset between clock edges while in LISTO -> outputs 0 immediately (async); after release, FSM is in ESPERA_A.
